// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the VGA raster timing generator: pixel enable in,
// sync/blank/coordinates/strobes/frame counter out.
interface vga_timing_gen_if #(
    parameter int CW      = 11,
    parameter int FRAME_W = 8
);
    logic               enable;
    logic               hsync;
    logic               vsync;
    logic               blank;
    logic [CW-1:0]      x_pos;
    logic [CW-1:0]      y_pos;
    logic               line_start;
    logic               frame_start;
    logic               prefetch;
    logic [FRAME_W-1:0] frame_count;

    modport master (
        input  enable,
        output hsync, vsync, blank, x_pos, y_pos,
        output line_start, frame_start, prefetch, frame_count
    );

    modport slave (
        output enable,
        input  hsync, vsync, blank, x_pos, y_pos,
        input  line_start, frame_start, prefetch, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/SVGA raster timing generator with registered outputs.
// Optional completed-frame counter is built only when VGA_FRAME_COUNT_EN is defined.
module vga_timing_gen #(
    parameter int WIDTH    = 800,
    parameter int HEIGHT   = 600,
    parameter int HFRONT   = 24,
    parameter int HSYNC    = 72,
    parameter int HBACK    = 128,
    parameter int VFRONT   = 1,
    parameter int VSYNC    = 2,
    parameter int VBACK    = 22,
    parameter bit HPOL     = 1'b1,
    parameter bit VPOL     = 1'b1,
    parameter int CW       = 11,
    parameter int PREFETCH = 2,
    parameter int FRAME_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    vga_timing_gen_if.master      bus
);
    localparam int HTOTAL = WIDTH + HFRONT + HSYNC + HBACK;
    localparam int VTOTAL = HEIGHT + VFRONT + VSYNC + VBACK;

    localparam logic [CW-1:0] H_LAST     = CW'(HTOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(VTOTAL - 1);
    localparam logic [CW-1:0] H_ACT      = CW'(WIDTH);
    localparam logic [CW-1:0] V_ACT      = CW'(HEIGHT);
    localparam logic [CW-1:0] V_ACT_LAST = CW'(HEIGHT - 1);
    localparam logic [CW-1:0] HS_START   = CW'(WIDTH + HFRONT);
    localparam logic [CW-1:0] HS_END     = CW'(WIDTH + HFRONT + HSYNC);
    localparam logic [CW-1:0] VS_START   = CW'(HEIGHT + VFRONT);
    localparam logic [CW-1:0] VS_END     = CW'(HEIGHT + VFRONT + VSYNC);
    localparam logic [CW-1:0] PF_H       = CW'(HTOTAL - PREFETCH);

    if ((HTOTAL - 1) >= (1 << CW) || (VTOTAL - 1) >= (1 << CW)) begin : g_cw_check
        $error("vga_timing_gen: CW too narrow for HTOTAL/VTOTAL");
    end
    if (PREFETCH < 1 || PREFETCH > (HFRONT + HSYNC + HBACK)) begin : g_pf_check
        $error("vga_timing_gen: PREFETCH out of range");
    end

    logic          started_q, started_d;
    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic          frame_wrap_d;

    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          blank_q, blank_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          prefetch_q, prefetch_d;

    // Raster position: the first enabled edge after reset presents (0,0) without advancing.
    always_comb begin
        started_d    = started_q;
        h_d          = h_q;
        v_d          = v_q;
        frame_wrap_d = 1'b0;
        if (bus.enable) begin
            started_d = 1'b1;
            if (!started_q) begin
                h_d = {CW{1'b0}};
                v_d = {CW{1'b0}};
            end else if (h_q == H_LAST) begin
                h_d = {CW{1'b0}};
                if (v_q == V_LAST) begin
                    v_d          = {CW{1'b0}};
                    frame_wrap_d = 1'b1;
                end else begin
                    v_d = v_q + CW'(1);
                end
            end else begin
                h_d = h_q + CW'(1);
            end
        end else begin
            started_d = started_q;
        end
    end

    // Output decode of the position being loaded; levels hold and strobes drop when disabled.
    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        blank_d       = blank_q;
        x_d           = x_q;
        y_d           = y_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        prefetch_d    = 1'b0;
        if (bus.enable) begin
            hsync_d       = (h_d >= HS_START && h_d < HS_END) ? HPOL : ~HPOL;
            vsync_d       = (v_d >= VS_START && v_d < VS_END) ? VPOL : ~VPOL;
            blank_d       = ~(h_d < H_ACT && v_d < V_ACT);
            x_d           = (h_d < H_ACT && v_d < V_ACT) ? h_d : {CW{1'b0}};
            y_d           = (v_d < V_ACT) ? v_d : {CW{1'b0}};
            line_start_d  = (h_d == {CW{1'b0}});
            frame_start_d = (h_d == {CW{1'b0}}) && (v_d == {CW{1'b0}});
            // the line after V_LAST is line 0, which is always active
            prefetch_d    = (h_d == PF_H) && ((v_d == V_LAST) || (v_d < V_ACT_LAST));
        end else begin
            line_start_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            started_q     <= 1'b0;
            h_q           <= {CW{1'b0}};
            v_q           <= {CW{1'b0}};
            hsync_q       <= ~HPOL;
            vsync_q       <= ~VPOL;
            blank_q       <= 1'b1;
            x_q           <= {CW{1'b0}};
            y_q           <= {CW{1'b0}};
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            prefetch_q    <= 1'b0;
        end else begin
            started_q     <= started_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_q       <= blank_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            prefetch_q    <= prefetch_d;
        end
    end

    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.blank       = blank_q;
    assign bus.x_pos       = x_q;
    assign bus.y_pos       = y_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;
    assign bus.prefetch    = prefetch_q;

`ifdef VGA_FRAME_COUNT_EN
    logic [FRAME_W-1:0] frame_count_q;

    // Completed-frame counter, bumped on the same edge that presents (0,0) after a wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_count_q <= {FRAME_W{1'b0}};
        end else if (frame_wrap_d) begin
            frame_count_q <= frame_count_q + FRAME_W'(1);
        end else begin
            frame_count_q <= frame_count_q;
        end
    end

    assign bus.frame_count = frame_count_q;
`else
    assign bus.frame_count = {FRAME_W{1'b0}};
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a small 16x8 raster (8x4 active).
module tb_vga_timing_gen;
    localparam int CW      = 5;
    localparam int FRAME_W = 2;

    logic clk;
    logic reset_n;

    int n_checks = 0;
    int n_errors = 0;
    int n_en     = 0;
    int cyc      = 0;
    int last_ls  = -1;
    int last_fs  = -1;
    int ls_per   = 16;
    int fs_per   = 128;
    int hs_run   = 0;
    logic hs_prev = 1'b0;

    vga_timing_gen_if #(.CW(CW), .FRAME_W(FRAME_W)) vif ();
    vga_timing_gen_if #(.CW(CW), .FRAME_W(FRAME_W)) vif2 ();

    vga_timing_gen #(
        .WIDTH(8), .HEIGHT(4), .HFRONT(2), .HSYNC(3), .HBACK(3),
        .VFRONT(1), .VSYNC(2), .VBACK(1), .HPOL(1'b1), .VPOL(1'b1),
        .CW(CW), .PREFETCH(2), .FRAME_W(FRAME_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(vif)
    );

    vga_timing_gen #(
        .WIDTH(8), .HEIGHT(4), .HFRONT(2), .HSYNC(3), .HBACK(3),
        .VFRONT(1), .VSYNC(2), .VBACK(1), .HPOL(1'b0), .VPOL(1'b0),
        .CW(CW), .PREFETCH(2), .FRAME_W(FRAME_W)
    ) dut_neg (
        .clk(clk), .reset_n(reset_n), .bus(vif2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (enabled edges %0d)", tag, obs, exp, n_en);
        end
    endtask

    task automatic check_reset();
        check("rst_hsync", vif.hsync, 0);
        check("rst_vsync", vif.vsync, 0);
        check("rst_blank", vif.blank, 1);
        check("rst_x", vif.x_pos, 0);
        check("rst_y", vif.y_pos, 0);
        check("rst_line", vif.line_start, 0);
        check("rst_frame", vif.frame_start, 0);
        check("rst_pf", vif.prefetch, 0);
        check("rst_fc", vif.frame_count, 0);
        check("rst_hsync_neg", vif2.hsync, 1);
        check("rst_vsync_neg", vif2.vsync, 1);
    endtask

    // Expected outputs for the position presented by the most recent enabled edge.
    task automatic check_all(input logic last_en);
        int p, h, v, efc;
        logic act;
        p   = n_en - 1;
        h   = p % 16;
        v   = (p / 16) % 8;
        act = (h < 8) && (v < 4);
`ifdef VGA_FRAME_COUNT_EN
        efc = (p / 128) % 4;
`else
        efc = 0;
`endif
        check("blank", vif.blank, !act);
        check("x_pos", vif.x_pos, act ? h : 0);
        check("y_pos", vif.y_pos, (v < 4) ? v : 0);
        check("hsync", vif.hsync, (h >= 10) && (h < 13));
        check("vsync", vif.vsync, (v >= 5) && (v < 7));
        check("line_start", vif.line_start, last_en && (h == 0));
        check("frame_start", vif.frame_start, last_en && (h == 0) && (v == 0));
        check("prefetch", vif.prefetch, last_en && (h == 14) && ((v < 3) || (v == 7)));
        check("frame_count", vif.frame_count, efc);
        check("hsync_neg", vif2.hsync, !((h >= 10) && (h < 13)));
        check("vsync_neg", vif2.vsync, !((v >= 5) && (v < 7)));
    endtask

    task automatic tick(input logic en);
        vif.enable  = en;
        vif2.enable = en;
        @(posedge clk);
        if (en) n_en++;
        cyc++;
        @(negedge clk);
        check_all(en);
        if (vif.line_start) begin
            if (last_ls >= 0) check("ls_period", cyc - last_ls, ls_per);
            last_ls = cyc;
        end
        if (vif.frame_start) begin
            if (last_fs >= 0) check("fs_period", cyc - last_fs, fs_per);
            last_fs = cyc;
        end
        if (vif.hsync) hs_run++;
        else if (hs_prev) begin
            check("hs_width", hs_run, 3 * (ls_per / 16));
            hs_run = 0;
        end
        hs_prev = vif.hsync;
    endtask

    initial begin
        reset_n     = 1'b0;
        vif.enable  = 1'b1;
        vif2.enable = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset();
        reset_n = 1'b1;

        // First enabled edge presents (0,0)
        tick(1'b1);
        check("first_blank", vif.blank, 0);
        check("first_x", vif.x_pos, 0);
        check("first_line", vif.line_start, 1);
        check("first_frame", vif.frame_start, 1);

        for (int i = 0; i < 2 * 128 + 20; i++) tick(1'b1);

        // Half-rate enable: periods double, strobes stay one clock wide
        last_ls = -1; last_fs = -1; ls_per = 32; fs_per = 256;
        for (int i = 0; i < 2 * 256 + 10; i++) tick(i[0] ? 1'b0 : 1'b1);

        // Reset mid-hsync: everything returns to reset values at once
        ls_per = 16; fs_per = 128;
        for (int i = 0; i < 16 && (((n_en - 1) % 16) != 11); i++) tick(1'b1);
        check("pre_rst_hsync", vif.hsync, 1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset();
        n_en = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset();
        reset_n = 1'b1;
        last_ls = -1; last_fs = -1; hs_run = 0; hs_prev = 1'b0;

        // Four full frames plus one edge: frame_count cycles through all values
        for (int i = 0; i < 4 * 128 + 1; i++) tick(1'b1);
`ifdef VGA_FRAME_COUNT_EN
        check("fc_wrap", vif.frame_count, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
